// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: digest-type encodings, block geometry, the length type
// and the byte-swap helper used by the padder and the other SHA-2 stages.
package sha2_pkg;

  typedef enum logic [1:0] {
    SHA_224 = 2'd0,
    SHA_256 = 2'd1,
    SHA_384 = 2'd2,
    SHA_512 = 2'd3
  } sha_type_e;

  typedef logic [63:0] len_t;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_PAD   = 2'd1,
    ST_LEN   = 2'd2,
    ST_DRAIN = 2'd3
  } pad_state_e;

  typedef struct packed {
    pad_state_e state;
    logic [1:0] sha_type;
  } pad_dbg_t;

  function automatic logic [7:0] block_bytes(input logic is_1024);
    return is_1024 ? 8'd128 : 8'd64;
  endfunction

  function automatic logic [7:0] len_bytes(input logic is_1024);
    return is_1024 ? 8'd16 : 8'd8;
  endfunction

  // Reverses byte order so a value lands MSB-first when stored at ascending byte lanes.
  function automatic logic [63:0] big_endian64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 8; i++) y[8*i +: 8] = x[8*(7-i) +: 8];
    return y;
  endfunction

endpackage

// File: rtl/sha2_stream_padder_if.sv
// Byte-lane AXI-Stream bundle used on both sides of the SHA-2 padder.
// A beat transfers on a rising edge where tvalid and tready are both high; the master holds
// tdata/tkeep/tlast stable while tvalid is high and tready is low, and never waits on tready.
interface sha2_stream_padder_if #(
  parameter int DATA_W = 64
) ();
  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sha2_block_assembler.sv
// Combinational byte-lane writer: merges an input beat, the 0x80 marker and the
// big-endian bit length into the 1024-bit assembly buffer at byte pointer ptr.
module sha2_block_assembler
  import sha2_pkg::*;
#(
  parameter int S_DATA_WIDTH = 64,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8
) (
  input  logic [1023:0]           blk_in,
  input  logic [7:0]              ptr,
  input  logic [S_DATA_WIDTH-1:0] beat_data,
  input  logic [S_KEEP_WIDTH-1:0] beat_keep,
  input  logic                    beat_en,
  input  logic                    marker_en,
  input  logic                    len_en,
  input  logic                    is_1024,
  input  len_t                    byte_count,
  output logic [1023:0]           blk_out
);
  logic [S_DATA_WIDTH-1:0] kept;
  logic [10:0]             shamt;
  logic [63:0]             len_lo;
  logic [63:0]             len_hi;

  // Bytes above ptr are always zero in the buffer, so OR-ing is enough to place new bytes.
  always_comb begin
    kept = '0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) begin
      kept[8*i +: 8] = beat_keep[i] ? beat_data[8*i +: 8] : 8'h00;
    end
    shamt   = {ptr, 3'b000};
    len_lo  = big_endian64({byte_count[60:0], 3'b000});
    len_hi  = big_endian64({61'd0, byte_count[63:61]});
    blk_out = blk_in;
    if (beat_en)   blk_out = blk_out | (1024'(kept) << shamt);
    if (marker_en) blk_out = blk_out | (1024'(8'h80) << shamt);
    if (len_en) begin
      if (is_1024) begin
        blk_out[1023:960] = blk_out[1023:960] | len_lo;
        blk_out[959:896]  = blk_out[959:896] | len_hi;
      end else begin
        blk_out[511:448]  = blk_out[511:448] | len_lo;
      end
    end
  end
endmodule

// File: rtl/sha2_stream_padder.sv
// SHA-2 message padder: packs byte-granular stream beats into 512/1024-bit blocks,
// appends the 0x80 marker, zero fill and bit length, one block per output beat.
module sha2_stream_padder
  import sha2_pkg::*;
#(
  parameter int S_DATA_WIDTH = 64,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8
) (
  input  logic                 axi_aclk,
  input  logic                 reset,
  input  logic [1:0]           sha_type,
  sha2_stream_padder_if.slave  s_axis,
  sha2_stream_padder_if.master m_axis,
  output logic                 m_axis_tuser,
  output pad_dbg_t             dbg_state
);
  pad_state_e    state_q, state_d;
  logic          alive_q, in_msg_q;
  logic [1:0]    mode_q;
  logic [7:0]    ptr_q;
  len_t          count_q;
  logic [1023:0] blk_q, asm_blk, out_data_q;
  logic          out_valid_q, out_last_q, out_user_q;

  logic       out_free, m_fire, accept_st, in_fire, first_beat, cur_1024;
  logic       wrap, fits, emit_pad, load_out, marker_en, len_en;
  logic [7:0] base_ptr, nbytes, new_ptr;
  len_t       base_count;

  always_comb begin
    nbytes = '0;
    for (int i = 0; i < S_KEEP_WIDTH; i++) nbytes = nbytes + 8'(s_axis.tkeep[i]);
  end

  // A beat may also be taken in DRAIN, as the first beat of the next message,
  // in the same cycle the final block leaves.
  assign out_free   = !out_valid_q || m_axis.tready;
  assign m_fire     = out_valid_q && m_axis.tready;
  assign accept_st  = (state_q == ST_FILL) || (state_q == ST_DRAIN);
  assign s_axis.tready = alive_q && accept_st && out_free;
  assign in_fire    = s_axis.tvalid && s_axis.tready;
  assign first_beat = !in_msg_q || (state_q == ST_DRAIN);
  assign cur_1024   = first_beat ? sha_type[1] : mode_q[1];
  assign base_ptr   = (state_q == ST_DRAIN) ? 8'd0 : ptr_q;
  assign base_count = (state_q == ST_DRAIN) ? '0 : count_q;
  assign new_ptr    = base_ptr + nbytes;
  assign wrap       = (new_ptr == block_bytes(cur_1024));
  assign fits       = ptr_q <= (block_bytes(mode_q[1]) - len_bytes(mode_q[1]) - 8'd1);
  assign emit_pad   = ((state_q == ST_PAD) || (state_q == ST_LEN)) && out_free;
  assign load_out   = (in_fire && wrap) || emit_pad;
  assign marker_en  = (state_q == ST_PAD);
  assign len_en     = ((state_q == ST_PAD) && fits) || (state_q == ST_LEN);

  sha2_block_assembler #(
    .S_DATA_WIDTH (S_DATA_WIDTH),
    .S_KEEP_WIDTH (S_KEEP_WIDTH)
  ) u_assembler (
    .blk_in     (blk_q),
    .ptr        (base_ptr),
    .beat_data  (s_axis.tdata),
    .beat_keep  (s_axis.tkeep),
    .beat_en    (accept_st),
    .marker_en  (marker_en),
    .len_en     (len_en),
    .is_1024    (cur_1024),
    .byte_count (count_q),
    .blk_out    (asm_blk)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:  if (in_fire && s_axis.tlast) state_d = ST_PAD;
      ST_PAD:   if (out_free) state_d = fits ? ST_DRAIN : ST_LEN;
      ST_LEN:   if (out_free) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (in_fire)     state_d = s_axis.tlast ? ST_PAD : ST_FILL;
        else if (m_fire) state_d = ST_FILL;
      end
      default:  state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      alive_q     <= 1'b0;
      in_msg_q    <= 1'b0;
      mode_q      <= 2'd0;
      ptr_q       <= 8'd0;
      count_q     <= '0;
      blk_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (in_fire) begin
        blk_q    <= wrap ? '0 : asm_blk;
        ptr_q    <= wrap ? 8'd0 : new_ptr;
        count_q  <= base_count + 64'(nbytes);
        in_msg_q <= 1'b1;
        if (first_beat) mode_q <= sha_type;
      end else if (emit_pad) begin
        blk_q <= '0;
      end else if ((state_q == ST_DRAIN) && m_fire) begin
        ptr_q    <= 8'd0;
        count_q  <= '0;
        in_msg_q <= 1'b0;
        mode_q   <= 2'd0;
      end
      if (load_out) begin
        out_data_q  <= asm_blk;
        out_valid_q <= 1'b1;
        out_last_q  <= (state_q == ST_LEN) || ((state_q == ST_PAD) && fits);
        out_user_q  <= cur_1024;
      end else if (m_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tdata       = out_data_q;
  assign m_axis.tkeep       = '1;
  assign m_axis.tvalid      = out_valid_q;
  assign m_axis.tlast       = out_last_q;
  assign m_axis_tuser       = out_user_q;
  assign dbg_state.state    = state_q;
  assign dbg_state.sha_type = mode_q;
endmodule
